instr_fetch_unit: RTL and testbench

- Upstream neighbour of the multicycle control FSM.
- Fetches one 32-bit instruction per request from a variable-latency instruction memory using a req/ack handshake.
- Holds the instruction in an internal IR and exposes the pre-sliced decode fields (opcode, func3, func7, rd, rs1, rs2) that the control FSM consumes.
- Reports misaligned-PC and (optionally) timeout faults.

---
 rtl/instr_fetch_unit_pkg.sv | 33 +++
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/instr_fetch_unit_timeout_ctr.sv | 29 ++
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch types and constants for the instruction fetch unit
// and the multicycle control FSM.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/ack bus between fetch unit and memory.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// REQ-state watchdog; built only with FETCH_TIMEOUT_EN.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires in the un-acked cycle whose increment would reach the limit.
  assign expired = active && (cnt == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-instruction fetch over a req/ack bus with IR and decode slices.
// Optional REQ timeout fault enabled by FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fault_clr,
  instr_fetch_unit_if.master mem,
  output logic [31:0]       instr,
  output logic [6:0]        opcode,
  output logic [2:0]        func3,
  output logic [6:0]        func7,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic              is_nop,
  output logic              instr_valid,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code
);

  fetch_state_t      state, state_nx;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        fcode;
  logic              aligned;
  logic              ack;
  logic              req_enter;
  logic              req_wait;
  logic              tmo_hit;

  assign aligned   = word_aligned(pc_in[1:0]);
  assign ack       = (state == REQ) && mem.mem_ack;
  assign req_wait  = (state == REQ) && !mem.mem_ack;
  assign req_enter = (state == IDLE) && fetch_start && aligned;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .start  (req_enter),
    .active (req_wait),
    .expired(tmo_hit)
  );
`else
  assign tmo_hit = (TIMEOUT_CYC < 0) && req_wait;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (fetch_start) begin
          state_nx = aligned ? REQ : FAULT;
        end
      end
      REQ: begin
        unique case (1'b1)
          ack:     state_nx = DONE;
          tmo_hit: state_nx = FAULT;
          default: state_nx = REQ;
        endcase
      end
      DONE:  state_nx = IDLE;
      FAULT: begin
        if (fault_clr) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir    <= NOP_INSTR;
      addr  <= '0;
      fcode <= FAULT_NONE;
    end else begin
      if (req_enter) begin
        addr <= pc_in;
      end
      if (ack) begin
        ir <= mem.mem_rdata;
      end
      unique case (1'b1)
        (state == IDLE) && fetch_start && !aligned:
          fcode <= FAULT_MISALIGN;
        tmo_hit:
          fcode <= FAULT_TIMEOUT;
        (state == FAULT) && fault_clr:
          fcode <= FAULT_NONE;
        default: ;
      endcase
    end
  end

  // Request is decoded from state so reset drops it without a clock.
  assign mem.mem_req  = (state == REQ);
  assign mem.mem_addr = addr;

  assign instr       = ir;
  assign opcode      = ir[6:0];
  assign rd          = ir[11:7];
  assign func3       = ir[14:12];
  assign rs1         = ir[19:15];
  assign rs2         = ir[24:20];
  assign func7       = ir[31:25];
  assign is_nop      = (ir == NOP_INSTR);
  assign instr_valid = (state == DONE);
  assign busy        = (state != IDLE);
  assign fault       = (state == FAULT);
  assign fault_code  = fcode;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a
// behavioural memory model.
module tb_instr_fetch_unit;
  import riscv_fetch_pkg::*;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_start;
  logic          fault_clr;
  logic [AW-1:0] pc_in;
  logic [31:0]   instr;
  logic [6:0]    opcode, func7;
  logic [2:0]    func3;
  logic [4:0]    rd, rs1, rs2;
  logic          is_nop, instr_valid, busy, fault;
  logic [1:0]    fault_code;

  instr_fetch_unit_if #(.ADDR_W(AW)) mem ();

  instr_fetch_unit #(
    .ADDR_W     (AW),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_start(fetch_start),
    .pc_in      (pc_in),
    .fault_clr  (fault_clr),
    .mem        (mem),
    .instr      (instr),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .is_nop     (is_nop),
    .instr_valid(instr_valid),
    .busy       (busy),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   word;
  } exp_t;

  exp_t          sbq[$];
  exp_t          e;
  int            errors = 0;
  int            checks = 0;
  int            valid_n = 0;
  int            delay_cfg = 0;
  int            wait_n = 0;
  int            req_run = 0;
  int            last_run = 0;
  logic [31:0]   word_cfg = '0;
  logic [AW-1:0] exp_pc = '0;
  bit            stray = 0;
  bit            req_seen = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory model: acks after delay_cfg waiting cycles.
  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem.mem_ack = 1'b0;
      if (mem.mem_req === 1'b1) begin
        req_seen = 1;
        req_run++;
        if (wait_n == delay_cfg) begin
          chk("mem_addr", mem.mem_addr, exp_pc);
          chk("req_len", req_run, delay_cfg + 1);
          mem.mem_ack   = 1'b1;
          mem.mem_rdata = word_cfg;
          sbq.push_back('{exp_pc, word_cfg});
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end else begin
        if (req_run > 0) last_run = req_run;
        req_run = 0;
        wait_n  = 0;
        if (stray) begin
          mem.mem_ack   = 1'b1;
          mem.mem_rdata = 32'hdeadbeef;
        end
      end
    end
  end

  // Monitor: every instr_valid pulse must match the oldest accepted word.
  initial begin
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: instr %h with nothing pending", instr);
        end else begin
          e = sbq.pop_front();
          valid_n++;
          chk("instr", instr, e.word);
          chk("opcode", opcode, e.word[6:0]);
          chk("rd", rd, e.word[11:7]);
          chk("func3", func3, e.word[14:12]);
          chk("rs1", rs1, e.word[19:15]);
          chk("rs2", rs2, e.word[24:20]);
          chk("func7", func7, e.word[31:25]);
          chk("is_nop", is_nop, e.word == 32'h00000013);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_stuck: busy %b want 0", name, busy);
    end
  endtask

  task automatic fetch(input logic [AW-1:0] pc, input int dly,
                       input logic [31:0] w, input bit poke);
    int v0;
    @(negedge clk);
    v0          = valid_n;
    exp_pc      = pc;
    delay_cfg   = dly;
    word_cfg    = w;
    pc_in       = pc;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    if (poke) begin
      pc_in       = pc + 64'h40;
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
    end
    wait_idle("fetch");
    repeat (2) @(negedge clk);
    chk("valid_count", valid_n, v0 + 1);
    chk("ir_hold", instr, w);
  endtask

  task automatic misalign(input logic [AW-1:0] pc);
    @(negedge clk);
    req_seen    = 0;
    pc_in       = pc;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("mis_fault", fault, 1'b1);
    chk("mis_code", fault_code, 2'b01);
    chk("mis_busy", busy, 1'b1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("mis_clr_fault", fault, 1'b0);
    chk("mis_clr_code", fault_code, 2'b00);
    chk("mis_no_req", req_seen, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] p;
    logic [31:0]   prev;
    int            v0;

    reset       = 1'b1;
    fetch_start = 1'b0;
    fault_clr   = 1'b0;
    pc_in       = '0;
    #1;
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_is_nop", is_nop, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", mem.mem_req, 1'b0);
    chk("rst_addr", mem.mem_addr, 64'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_code", fault_code, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Minimum latency fetch: add x10, x10, x11
    @(negedge clk);
    exp_pc      = 64'h100;
    delay_cfg   = 0;
    word_cfg    = 32'h00b50533;
    pc_in       = 64'h100;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("lat_req_n1", mem.mem_req, 1'b1);
    @(negedge clk);
    chk("lat_valid_n2", instr_valid, 1'b1);
    chk("lat_opcode", opcode, 7'h33);
    chk("lat_func3", func3, 3'd0);
    chk("lat_func7", func7, 7'd0);
    chk("lat_rd", rd, 5'd10);
    chk("lat_rs1", rs1, 5'd10);
    chk("lat_rs2", rs2, 5'd11);
    @(negedge clk);
    chk("lat_pulse", instr_valid, 1'b0);
    chk("lat_idle", busy, 1'b0);

    // Misaligned, then clear and start together: start must be dropped
    @(negedge clk);
    req_seen    = 0;
    pc_in       = 64'h102;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("mis102_fault", fault, 1'b1);
    chk("mis102_code", fault_code, 2'b01);
    repeat (3) @(negedge clk);
    chk("mis102_hold", fault_code, 2'b01);
    fault_clr   = 1'b1;
    fetch_start = 1'b1;
    pc_in       = 64'h200;
    @(negedge clk);
    fault_clr   = 1'b0;
    fetch_start = 1'b0;
    chk("clr_busy", busy, 1'b0);
    chk("clr_fault", fault, 1'b0);
    chk("clr_code", fault_code, 2'b00);
    repeat (3) @(negedge clk);
    chk("clr_no_fetch", req_seen, 1'b0);
    chk("clr_ir", instr, 32'h00b50533);

    // Delayed ack with an ignored start during REQ
    fetch(64'h2000, 5, 32'h40c58633, 1'b1);
    fetch(64'h300, 2, NOP_INSTR, 1'b0);
    chk("nop_flag", is_nop, 1'b1);

    for (int i = 0; i < 25; i++) begin
      p = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) begin
        p[1:0] = 2'($urandom_range(1, 3));
        misalign(p);
      end else begin
        p[1:0] = 2'b00;
        fetch(p, $urandom_range(0, 6), $urandom, 1'($urandom_range(0, 1)));
      end
    end

`ifdef FETCH_TIMEOUT_EN
    prev = instr;
    @(negedge clk);
    exp_pc      = 64'h400;
    delay_cfg   = 1000;
    pc_in       = 64'h400;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    repeat (8) @(negedge clk);
    chk("tmo_req_len", last_run, 4);
    chk("tmo_req", mem.mem_req, 1'b0);
    chk("tmo_fault", fault, 1'b1);
    chk("tmo_code", fault_code, 2'b10);
    chk("tmo_ir", instr, prev);
    stray = 1;
    @(negedge clk);
    stray = 0;
    @(negedge clk);
    chk("tmo_stray_ir", instr, prev);
    chk("tmo_stray_fault", fault, 1'b1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("tmo_clr", fault_code, 2'b00);
`endif

    // Reset in the middle of REQ, then a late ack
    v0 = valid_n;
    @(negedge clk);
    exp_pc      = 64'h500;
    delay_cfg   = 1000;
    pc_in       = 64'h500;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    chk("mid_req", mem.mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_req_drop", mem.mem_req, 1'b0);
    chk("mid_rst_ir", instr, 32'h00000013);
    @(negedge clk);
    reset = 1'b0;
    stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (3) @(negedge clk);
    chk("late_ack_ir", instr, 32'h00000013);
    chk("late_ack_nop", is_nop, 1'b1);
    chk("late_ack_busy", busy, 1'b0);
    chk("late_ack_valid", valid_n, v0);

    delay_cfg = 0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
